// File: rtl/dbg_guv_cmd_sched.sv
// -----------------------------------------------------------------------------
// dbg_guv_cmd_sched
//
// Command sequencer for the debug governor datapath. The block decodes 29-bit
// commands from the cmd_in AXI-Stream and drives one-hot per-channel
// drop / inject / pause / log enables into the datapath. Each operation ends
// after a programmed number of accepted beats on its channel, or of clock
// cycles for PAUSE. The block reports done, abort and error status back to the
// control layer. One command can wait in a pending slot behind the active one,
// so back-to-back operations run with only the single DONE cycle between them.
//
// Command word: [28:26] opcode, [25:23] channel, [22:0] count
//   0 NOP, 1 DROP, 2 INJECT, 3 PAUSE, 4 LOG, 5 ABORT, 6-7 illegal
//   A count of 0 means the operation runs until it is aborted.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_in_TDATA      command word
//   cmd_in_TVALID     command valid
//   cmd_in_TREADY     command ready (low while the pending slot is full or in reset)
//   chan_beat         per-channel pulse: one beat accepted by the datapath
//   drop_en           one-hot drop enable
//   inject_en         one-hot inject enable
//   pause_en          one-hot pause enable
//   log_en            one-hot log enable
//   busy              an operation is active or completing
//   op_done           one-cycle pulse: the operation finished
//   op_aborted        qualifies op_done: the operation was ended by ABORT
//   cmd_err           one-cycle pulse: an illegal command was consumed
//   remaining         beats or cycles left in the active operation
// -----------------------------------------------------------------------------
module dbg_guv_cmd_sched #(
  parameter int NUM_CHAN = 5,
  parameter int CNT_W    = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [28:0]         cmd_in_TDATA,
  input  logic                cmd_in_TVALID,
  output logic                cmd_in_TREADY,
  input  logic [NUM_CHAN-1:0] chan_beat,
  output logic [NUM_CHAN-1:0] drop_en,
  output logic [NUM_CHAN-1:0] inject_en,
  output logic [NUM_CHAN-1:0] pause_en,
  output logic [NUM_CHAN-1:0] log_en,
  output logic                busy,
  output logic                op_done,
  output logic                op_aborted,
  output logic                cmd_err,
  output logic [CNT_W-1:0]    remaining
);

  // Opcode values. NOP (0) needs no decode: it is consumed and has no effect.
  localparam logic [2:0] OPC_DROP   = 3'd1;
  localparam logic [2:0] OPC_INJECT = 3'd2;
  localparam logic [2:0] OPC_PAUSE  = 3'd3;
  localparam logic [2:0] OPC_LOG    = 3'd4;
  localparam logic [2:0] OPC_ABORT  = 3'd5;

  localparam logic [3:0] NUM_CHAN_L = 4'(NUM_CHAN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [2:0]       cmd_opc;
  logic [2:0]       cmd_ch;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_accept;
  logic             cmd_is_op;
  logic             cmd_ch_ok;
  logic             cmd_start;
  logic             cmd_abort;
  logic             cmd_illegal;

  assign cmd_opc = cmd_in_TDATA[28:26];
  assign cmd_ch  = cmd_in_TDATA[25:23];
  assign cmd_cnt = cmd_in_TDATA[CNT_W-1:0];

  logic             pend_valid_q, pend_valid_d;

  // Ready depends only on the pending slot and reset, never on TDATA.
  assign cmd_in_TREADY = !rst && !pend_valid_q;
  assign cmd_accept    = cmd_in_TVALID && cmd_in_TREADY;

  assign cmd_is_op   = (cmd_opc >= OPC_DROP) && (cmd_opc <= OPC_LOG);
  assign cmd_ch_ok   = {1'b0, cmd_ch} < NUM_CHAN_L;
  assign cmd_start   = cmd_accept && cmd_is_op && cmd_ch_ok;
  assign cmd_abort   = cmd_accept && (cmd_opc == OPC_ABORT);
  assign cmd_illegal = cmd_accept && ((cmd_opc > OPC_ABORT) || (cmd_is_op && !cmd_ch_ok));

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             aborted_q, aborted_d;
  logic             err_q;
  logic [2:0]       pend_op_q, pend_op_d;
  logic [2:0]       pend_sel_q, pend_sel_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;

  // One unit of progress: a beat on the selected channel, or any cycle for PAUSE.
  logic tick;
  logic last_tick;

  assign tick      = (op_q == OPC_PAUSE) || chan_beat[sel_q];
  // A count of 0 never reaches 1, so indefinite operations only end on ABORT.
  assign last_tick = (state_q == S_ACTIVE) && tick && (rem_q == CNT_W'(1));

  always_comb begin
    // NOTE: every signal written here receives a default first, so no path
    // through the case statement leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    op_d         = op_q;
    sel_d        = sel_q;
    rem_d        = rem_q;
    aborted_d    = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_sel_d   = pend_sel_q;
    pend_cnt_d   = pend_cnt_q;

    case (state_q)
      S_IDLE: begin
        // ABORT in IDLE falls through as a no-op.
        if (cmd_start) begin
          op_d    = cmd_opc;
          sel_d   = cmd_ch;
          rem_d   = cmd_cnt;
          state_d = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        // A new operation can only be accepted while the slot is empty.
        if (cmd_start) begin
          pend_valid_d = 1'b1;
          pend_op_d    = cmd_opc;
          pend_sel_d   = cmd_ch;
          pend_cnt_d   = cmd_cnt;
        end
        // The final covered beat wins over an ABORT in the same cycle; the
        // ABORT is consumed and discarded.
        if (last_tick) begin
          state_d = S_DONE;
          rem_d   = '0;
        end else if (cmd_abort) begin
          state_d   = S_DONE;
          rem_d     = '0;
          aborted_d = 1'b1;
        end else if (tick && (rem_q != '0)) begin
          rem_d = rem_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        if (pend_valid_q) begin
          op_d         = pend_op_q;
          sel_d        = pend_sel_q;
          rem_d        = pend_cnt_q;
          pend_valid_d = 1'b0;
          state_d      = S_ACTIVE;
        end else if (cmd_start) begin
          // The slot is empty, so a command taken in the DONE cycle starts
          // directly, exactly as it would from IDLE.
          op_d    = cmd_opc;
          sel_d   = cmd_ch;
          rem_d   = cmd_cnt;
          state_d = S_ACTIVE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      aborted_q    <= 1'b0;
      err_q        <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      aborted_q    <= aborted_d;
      err_q        <= cmd_illegal;
      pend_valid_q <= pend_valid_d;
    end
  end

  // NOTE: the operation and pending payload registers carry no reset. They are
  // only observed while state_q or pend_valid_q says they hold a live command,
  // and both of those flags are reset.
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    sel_q      <= sel_d;
    pend_op_q  <= pend_op_d;
    pend_sel_q <= pend_sel_d;
    pend_cnt_q <= pend_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [NUM_CHAN-1:0] sel_onehot;

  always_comb begin
    sel_onehot        = '0;
    sel_onehot[sel_q] = 1'b1;
  end

  always_comb begin
    drop_en   = '0;
    inject_en = '0;
    pause_en  = '0;
    log_en    = '0;
    if (state_q == S_ACTIVE) begin
      case (op_q)
        OPC_DROP:   drop_en   = sel_onehot;
        OPC_INJECT: inject_en = sel_onehot;
        OPC_PAUSE:  pause_en  = sel_onehot;
        default:    log_en    = sel_onehot;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign op_done    = (state_q == S_DONE);
  assign op_aborted = (state_q == S_DONE) && aborted_q;
  assign cmd_err    = err_q;
  assign remaining  = rem_q;

endmodule

// File: tb/tb_dbg_guv_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_dbg_guv_cmd_sched
//
// Self-checking bench for dbg_guv_cmd_sched. A transaction-level reference
// model holds the running operation and its pending successor in a queue and
// predicts every output once per cycle. Each scenario task drives its own
// stimulus, compares the DUT against the model after every clock, and adds
// targeted checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_dbg_guv_cmd_sched;

  logic        clk;
  logic        rst;
  logic [28:0] cmd_in_TDATA;
  logic        cmd_in_TVALID;
  logic        cmd_in_TREADY;
  logic [4:0]  chan_beat;
  logic [4:0]  drop_en;
  logic [4:0]  inject_en;
  logic [4:0]  pause_en;
  logic [4:0]  log_en;
  logic        busy;
  logic        op_done;
  logic        op_aborted;
  logic        cmd_err;
  logic [22:0] remaining;

  int n_checks;
  int n_fail;

  dbg_guv_cmd_sched #(.NUM_CHAN(5), .CNT_W(23)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_in_TDATA (cmd_in_TDATA),
    .cmd_in_TVALID(cmd_in_TVALID),
    .cmd_in_TREADY(cmd_in_TREADY),
    .chan_beat    (chan_beat),
    .drop_en      (drop_en),
    .inject_en    (inject_en),
    .pause_en     (pause_en),
    .log_en       (log_en),
    .busy         (busy),
    .op_done      (op_done),
    .op_aborted   (op_aborted),
    .cmd_err      (cmd_err),
    .remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] dut_all;
  assign dut_all = {drop_en, inject_en, pause_en, log_en,
                    busy, op_done, op_aborted, cmd_err, cmd_in_TREADY, remaining};

  // ---------------------------------------------------------------------------
  // Reference model
  // m_ops[0] is the running operation and m_ops[1] the pending one. While
  // m_gap is set the finished operation has been retired and the DONE cycle is
  // in progress, so any entry left in m_ops is the one waiting to start.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]  opc;
    logic [2:0]  ch;
    logic [22:0] cnt;
  } cmd_t;

  cmd_t m_ops[$];
  int   m_left = 0;
  bit   m_gap  = 1'b0;
  bit   m_ab   = 1'b0;
  bit   m_err  = 1'b0;

  function automatic bit m_pend_full();
    return m_gap ? (m_ops.size() >= 1) : (m_ops.size() >= 2);
  endfunction

  function automatic logic [47:0] exp_all();
    logic [4:0]  oh;
    logic [19:0] en;
    bit          running;
    oh      = '0;
    en      = '0;
    running = !m_gap && (m_ops.size() > 0);
    if (running) begin
      oh = 5'b00001 << m_ops[0].ch;
      case (m_ops[0].opc)
        3'd1:    en[19:15] = oh;
        3'd2:    en[14:10] = oh;
        3'd3:    en[9:5]   = oh;
        default: en[4:0]   = oh;
      endcase
    end
    return {en, (m_gap || (m_ops.size() > 0)), m_gap, (m_gap && m_ab), m_err,
            (!rst && !m_pend_full()), (running ? 23'(m_left) : 23'd0)};
  endfunction

  // Advances the model by one clock using the inputs presented at this edge.
  task automatic model_step();
    cmd_t c;
    bit   acc, is_op, legal, abort, illegal, unit;
    if (rst) begin
      m_ops.delete();
      m_left = 0;
      m_gap  = 1'b0;
      m_ab   = 1'b0;
      m_err  = 1'b0;
      return;
    end
    c       = cmd_in_TDATA;
    acc     = cmd_in_TVALID && !m_pend_full();
    is_op   = (c.opc >= 3'd1) && (c.opc <= 3'd4);
    legal   = acc && is_op && (c.ch < 3'd5);
    abort   = acc && (c.opc == 3'd5);
    illegal = acc && ((c.opc >= 3'd6) || (is_op && c.ch >= 3'd5));
    m_err   = illegal;
    if (m_gap) begin
      m_gap = 1'b0;
      m_ab  = 1'b0;
      if (m_ops.size() > 0) begin
        m_left = int'(m_ops[0].cnt);
      end else if (legal) begin
        m_ops.push_back(c);
        m_left = int'(c.cnt);
      end
    end else if (m_ops.size() == 0) begin
      if (legal) begin
        m_ops.push_back(c);
        m_left = int'(c.cnt);
      end
    end else begin
      unit = (m_ops[0].opc == 3'd3) || chan_beat[m_ops[0].ch];
      if (legal) m_ops.push_back(c);
      if (unit && m_left == 1) begin
        void'(m_ops.pop_front());
        m_gap = 1'b1;
        m_ab  = 1'b0;
      end else if (abort) begin
        void'(m_ops.pop_front());
        m_gap = 1'b1;
        m_ab  = 1'b1;
      end else if (unit && m_left > 0) begin
        m_left = m_left - 1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus driver: inputs change on the falling edge, outputs are observed
  // on the next falling edge.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        v;
    logic [28:0] d;
    logic [4:0]  b;
    logic        r;
  } stim_t;

  function automatic logic [28:0] mk(input int opc, input int ch, input int cnt);
    return {3'(opc), 3'(ch), 23'(cnt)};
  endfunction

  function automatic stim_t st(input logic v, input logic [28:0] d, input logic [4:0] b,
                               input logic r);
    stim_t s;
    s.v = v; s.d = d; s.b = b; s.r = r;
    return s;
  endfunction

  task automatic step(input stim_t s);
    rst           = s.r;
    cmd_in_TVALID = s.v;
    cmd_in_TDATA  = s.d;
    chan_beat     = s.b;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    stim_t sq[$];
    sq.push_back(st(1'b1, mk(1, 1, 3), 5'b11111, 1'b1));
    sq.push_back(st(1'b0, '0, '0, 1'b1));
    sq.push_back(st(1'b0, '0, '0, 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL reset_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      n_checks++;
      if (dut_all !== {43'd0, (i == 2), 23'd0} && i >= 1) begin
        n_fail++;
        $display("FAIL reset_state step %0d: dut %h", i, dut_all);
      end
    end
  endtask

  task automatic test_drop_basic();
    stim_t sq[$];
    sq.push_back(st(1'b1, mk(1, 1, 3), 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b11101, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00010, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b11101, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00010, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00010, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL drop_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      if (i <= 4) begin
        n_checks++;
        if (drop_en !== 5'b00010) begin
          n_fail++;
          $display("FAIL drop_en cycle %0d: got %b want 00010", i + 1, drop_en);
        end
      end
      if (i == 5) begin
        n_checks++;
        if ({op_done, op_aborted, drop_en} !== 7'b10_00000) begin
          n_fail++;
          $display("FAIL drop_done: got done=%b aborted=%b en=%b want 1 0 00000",
                   op_done, op_aborted, drop_en);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL drop_idle: busy got %b want 0", busy);
        end
      end
    end
  endtask

  task automatic test_pause();
    stim_t sq[$];
    int    held;
    held = 0;
    sq.push_back(st(1'b1, mk(3, 4, 4), 5'($urandom), 1'b0));
    for (int k = 0; k < 7; k++) sq.push_back(st(1'b0, '0, 5'($urandom), 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL pause_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      if (pause_en == 5'b10000) held++;
      if (i == 4) begin
        n_checks++;
        if (op_done !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_done: op_done got %b want 1", op_done);
        end
      end
    end
    n_checks++;
    if (held != 4) begin
      n_fail++;
      $display("FAIL pause_length: pause_en held %0d cycles want 4", held);
    end
  endtask

  task automatic test_log_abort();
    stim_t sq[$];
    sq.push_back(st(1'b1, mk(4, 0, 0), 5'b00000, 1'b0));
    for (int k = 0; k < 20; k++) sq.push_back(st(1'b0, '0, 5'b00001, 1'b0));
    sq.push_back(st(1'b1, mk(5, 0, 0), 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL log_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      if (i <= 20) begin
        n_checks++;
        if ({log_en, remaining} !== {5'b00001, 23'd0}) begin
          n_fail++;
          $display("FAIL log_hold step %0d: log_en=%b remaining=%0d want 00001 0",
                   i, log_en, remaining);
        end
      end
      if (i == 21) begin
        n_checks++;
        if ({op_done, op_aborted, log_en} !== 7'b11_00000) begin
          n_fail++;
          $display("FAIL log_abort: done=%b aborted=%b en=%b want 1 1 00000",
                   op_done, op_aborted, log_en);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t       sq[$];
    logic [28:0] third;
    third = mk(4, 1, 1);
    sq.push_back(st(1'b1, mk(2, 3, 2), 5'b00000, 1'b0));
    sq.push_back(st(1'b1, mk(1, 2, 1), 5'b00000, 1'b0));
    sq.push_back(st(1'b1, third, 5'b01000, 1'b0));
    sq.push_back(st(1'b1, third, 5'b01000, 1'b0));
    sq.push_back(st(1'b1, third, 5'b00000, 1'b0));
    sq.push_back(st(1'b1, third, 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00100, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00010, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL b2b_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (cmd_in_TREADY !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_low step %0d: got %b want 0", i, cmd_in_TREADY);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (op_done !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_done: op_done got %b want 1", op_done);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({drop_en, cmd_in_TREADY} !== 6'b00100_1) begin
          n_fail++;
          $display("FAIL b2b_next: drop_en=%b ready=%b want 00100 1", drop_en, cmd_in_TREADY);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (log_en !== 5'b00010) begin
          n_fail++;
          $display("FAIL b2b_third: log_en got %b want 00010", log_en);
        end
      end
    end
  endtask

  task automatic test_abort_race();
    stim_t sq[$];
    sq.push_back(st(1'b1, mk(1, 2, 1), 5'b00000, 1'b0));
    sq.push_back(st(1'b1, mk(5, 0, 0), 5'b00100, 1'b0));
    sq.push_back(st(1'b1, mk(5, 0, 0), 5'b00000, 1'b0));
    sq.push_back(st(1'b1, mk(5, 0, 0), 5'b00000, 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL race_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      if (i == 1) begin
        n_checks++;
        if ({op_done, op_aborted} !== 2'b10) begin
          n_fail++;
          $display("FAIL race_done: done=%b aborted=%b want 1 0", op_done, op_aborted);
        end
      end
      if (i == 3) begin
        n_checks++;
        if ({busy, op_done} !== 2'b00) begin
          n_fail++;
          $display("FAIL idle_abort: busy=%b done=%b want 0 0", busy, op_done);
        end
      end
    end
  endtask

  task automatic test_illegal();
    stim_t sq[$];
    sq.push_back(st(1'b1, mk(7, 0, 3), 5'b11111, 1'b0));
    sq.push_back(st(1'b1, mk(1, 6, 5), 5'b11111, 1'b0));
    sq.push_back(st(1'b1, mk(0, 1, 2), 5'b11111, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL illegal_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      n_checks++;
      if ({drop_en, inject_en, pause_en, log_en, busy, cmd_err} !== {21'd0, (i <= 1)}) begin
        n_fail++;
        $display("FAIL illegal_effect step %0d: en=%h busy=%b cmd_err=%b want 0 0 %b",
                 i, {drop_en, inject_en, pause_en, log_en}, busy, cmd_err, (i <= 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t sq[$];
    sq.push_back(st(1'b1, mk(1, 1, 5), 5'b00000, 1'b0));
    sq.push_back(st(1'b1, mk(2, 0, 2), 5'b00000, 1'b0));
    sq.push_back(st(1'b0, '0, 5'b00000, 1'b1));
    for (int k = 0; k < 5; k++) sq.push_back(st(1'b0, '0, 5'b11111, 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL rstmid_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
      if (i == 1) begin
        n_checks++;
        if ({remaining, cmd_in_TREADY} !== {23'd5, 1'b0}) begin
          n_fail++;
          $display("FAIL rstmid_setup: remaining=%0d ready=%b want 5 0", remaining, cmd_in_TREADY);
        end
      end
      if (i >= 2) begin
        n_checks++;
        if ({drop_en, inject_en, pause_en, log_en, busy, op_done} !== 22'd0) begin
          n_fail++;
          $display("FAIL rstmid_clear step %0d: en=%h busy=%b done=%b want 0",
                   i, {drop_en, inject_en, pause_en, log_en}, busy, op_done);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (cmd_in_TREADY !== 1'b1) begin
          n_fail++;
          $display("FAIL rstmid_ready: got %b want 1", cmd_in_TREADY);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    int    o;
    int    opc;
    int    ch;
    for (int i = 0; i < 3000; i++) begin
      o = $urandom_range(0, 15);
      opc = (o < 2) ? 0 : (o < 5) ? 1 : (o < 7) ? 2 : (o < 9) ? 3 :
            (o < 11) ? 4 : (o < 14) ? 5 : o - 8;
      ch = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      s = st(1'($urandom_range(0, 1)), mk(opc, ch, $urandom_range(0, 5)),
             5'($urandom), ($urandom_range(0, 199) == 0));
      step(s);
      n_checks++;
      if (dut_all !== exp_all()) begin
        n_fail++;
        $display("FAIL random_model step %0d: dut %h expected %h", i, dut_all, exp_all());
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    cmd_in_TVALID = 1'b0;
    cmd_in_TDATA  = '0;
    chan_beat     = '0;
    @(negedge clk);
    test_reset();
    test_drop_basic();
    test_pause();
    test_log_abort();
    test_back_to_back();
    test_abort_race();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
